// File: rtl/ecall_sequencer_pkg.sv
// Shared definitions for the ecall sequencer: service codes, FSM state
// encoding and the writeback register index.
package ecall_sequencer_pkg;

    localparam logic [31:0] SVC_PRINT_INT = 32'd1;
    localparam logic [31:0] SVC_READ_INT  = 32'd5;
    localparam logic [31:0] SVC_EXIT      = 32'd10;

    localparam logic [4:0]  REG_A0        = 5'd10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_BTN = 2'd1,
        ST_DONE     = 2'd2,
        ST_HALT     = 2'd3
    } seq_state_e;

endpackage

// File: rtl/ecall_sequencer_btn_sync_edge.sv
// Confirm-button conditioning: two-flop synchronizer followed by a
// one-cycle rising-edge pulse generator.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic sync_prev_q, sync_prev_d;

    // Next-state of the synchronizer chain and the edge-detect history flop.
    always_comb begin
        meta_d      = btn_i;
        sync_d      = meta_q;
        sync_prev_d = sync_q;
    end

    // Synchronizer and history flops, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q      <= 1'b0;
            sync_q      <= 1'b0;
            sync_prev_q <= 1'b0;
        end else begin
            meta_q      <= meta_d;
            sync_q      <= sync_d;
            sync_prev_q <= sync_prev_d;
        end
    end

    // A press is the first cycle the synchronized level is seen high.
    assign press_o = sync_q & ~sync_prev_q;

endmodule

// File: rtl/ecall_sequencer.sv
// Environment-call sequencer: stalls fetch while an ecall is serviced against
// the board I/O and returns read results to x10 through a writeback side-port.
module ecall_sequencer
    import ecall_sequencer_pkg::*;
#(
    parameter int SW_WIDTH      = 16,
    parameter bit AUTO_CONTINUE = 1'b0,
    parameter int PC_WIDTH      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ecall_i,
    input  logic [31:0]         a7_value,
    input  logic [31:0]         a0_value,
    input  logic [SW_WIDTH-1:0] switches,
    input  logic                confirm_btn,
    output logic                stall,
    output logic                wb_en,
    output logic [4:0]          wb_sel,
    output logic [31:0]         wb_data,
    output logic [31:0]         seg_value,
    output logic                seg_valid,
    output logic                halted
);

    // The PC itself lives in the fetch unit; only sanity-check its width here.
    if (PC_WIDTH < 1) begin : g_pc_width_check
        $error("ecall_sequencer: PC_WIDTH must be positive");
    end

    seq_state_e  state_q, state_d;
    logic        read_q, read_d;
    logic        wb_en_q, wb_en_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] seg_value_q, seg_value_d;
    logic        seg_valid_q, seg_valid_d;
    logic        halted_q, halted_d;
    logic        press_s;
    logic        stall_s;

    btn_sync_edge u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (confirm_btn),
        .press_o (press_s)
    );

    // Service decode and state sequencing; wb_en is precomputed so that it is
    // a flop output that is high exactly during the DONE cycle.
    always_comb begin
        state_d     = state_q;
        read_d      = read_q;
        wb_en_d     = 1'b0;
        wb_data_d   = wb_data_q;
        seg_value_d = seg_value_q;
        seg_valid_d = seg_valid_q;
        halted_d    = halted_q;
        case (state_q)
            ST_IDLE: begin
                if (ecall_i) begin
                    if (a7_value == SVC_PRINT_INT) begin
                        seg_value_d = a0_value;
                        seg_valid_d = 1'b1;
                        read_d      = 1'b0;
                        state_d     = AUTO_CONTINUE ? ST_DONE : ST_WAIT_BTN;
                    end else if (a7_value == SVC_READ_INT) begin
                        read_d  = 1'b1;
                        state_d = ST_WAIT_BTN;
                    end else if (a7_value == SVC_EXIT) begin
                        read_d   = 1'b0;
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        read_d  = 1'b0;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_BTN: begin
                if (press_s) begin
                    state_d = ST_DONE;
                    wb_en_d = read_q;
                    if (read_q) begin
                        wb_data_d = 32'(switches);
                    end else begin
                        wb_data_d = wb_data_q;
                    end
                end else begin
                    state_d = ST_WAIT_BTN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_HALT: begin
                state_d  = ST_HALT;
                halted_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            read_q      <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_data_q   <= 32'd0;
            seg_value_q <= 32'd0;
            seg_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_q      <= read_d;
            wb_en_q     <= wb_en_d;
            wb_data_q   <= wb_data_d;
            seg_value_q <= seg_value_d;
            seg_valid_q <= seg_valid_d;
            halted_q    <= halted_d;
        end
    end

    // PC hold: the ecall cycle itself stalls, DONE lets the PC step past it.
    always_comb begin
        stall_s = 1'b0;
        if (rst) begin
            stall_s = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:     stall_s = ecall_i;
                ST_WAIT_BTN: stall_s = 1'b1;
                ST_DONE:     stall_s = 1'b0;
                ST_HALT:     stall_s = 1'b1;
                default:     stall_s = 1'b0;
            endcase
        end
    end

    assign stall     = stall_s;
    assign wb_en     = wb_en_q;
    assign wb_sel    = REG_A0;
    assign wb_data   = wb_data_q;
    assign seg_value = seg_value_q;
    assign seg_valid = seg_valid_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_ecall_sequencer.sv
// Self-checking bench for ecall_sequencer (AUTO_CONTINUE = 0): directed
// scenarios followed by randomized traffic, all checked against a
// service-level reference model.
module tb_ecall_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ecall_i;
    logic [31:0] a7_value;
    logic [31:0] a0_value;
    logic [15:0] switches;
    logic        confirm_btn;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_sel;
    logic [31:0] wb_data;
    logic [31:0] seg_value;
    logic        seg_valid;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    // Reference model: what the current call is doing, plus button history.
    bit          m_wait;       // call waits for a confirm press
    bit          m_read;       // current call is a read service
    bit          m_done;       // this cycle completes the call
    bit          m_halt;       // exit taken
    bit          m_seg_valid;
    logic [31:0] m_seg;
    logic [31:0] m_wb_data;
    logic [2:0]  bhist;        // raw button seen at last three edges, [0] newest

    logic        obs_stall;
    logic        obs_wb_en;
    logic        obs_halted;
    logic        obs_seg_valid;
    logic [31:0] obs_wb_data;
    logic [31:0] obs_seg;

    always #5 clk = ~clk;

    ecall_sequencer #(
        .SW_WIDTH      (16),
        .AUTO_CONTINUE (1'b0),
        .PC_WIDTH      (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ecall_i     (ecall_i),
        .a7_value    (a7_value),
        .a0_value    (a0_value),
        .switches    (switches),
        .confirm_btn (confirm_btn),
        .stall       (stall),
        .wb_en       (wb_en),
        .wb_sel      (wb_sel),
        .wb_data     (wb_data),
        .seg_value   (seg_value),
        .seg_valid   (seg_valid),
        .halted      (halted)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        m_wait      = 1'b0;
        m_read      = 1'b0;
        m_done      = 1'b0;
        m_halt      = 1'b0;
        m_seg_valid = 1'b0;
        m_seg       = 32'd0;
        m_wb_data   = 32'd0;
        bhist       = 3'b000;
    endtask

    // Advance the model across one clock edge.
    task automatic mdl_step(input logic e, input logic [31:0] a7, input logic [31:0] a0,
                            input logic [15:0] sw, input logic b);
        bit press;
        press = bhist[1] && !bhist[2];
        if (m_halt) begin
            m_halt = 1'b1;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_wait) begin
            if (press) begin
                m_wait = 1'b0;
                m_done = 1'b1;
                if (m_read) m_wb_data = {16'h0000, sw};
            end
        end else if (e) begin
            if (a7 == 32'd1) begin
                m_seg       = a0;
                m_seg_valid = 1'b1;
                m_read      = 1'b0;
                m_wait      = 1'b1;
            end else if (a7 == 32'd5) begin
                m_read = 1'b1;
                m_wait = 1'b1;
            end else if (a7 == 32'd10) begin
                m_halt = 1'b1;
            end else begin
                m_read = 1'b0;
                m_done = 1'b1;
            end
        end
        bhist = {bhist[1:0], b};
    endtask

    // Drive one cycle of inputs, check every output mid-cycle, advance model.
    task automatic cycle(input logic e, input logic [31:0] a7, input logic [31:0] a0,
                         input logic [15:0] sw, input logic b, input logic r);
        bit exp_stall;
        bit idle;
        rst         = r;
        ecall_i     = e;
        a7_value    = a7;
        a0_value    = a0;
        switches    = sw;
        confirm_btn = b;
        if (r) mdl_reset();
        @(negedge clk);
        idle      = !(m_wait || m_done || m_halt);
        exp_stall = !r && (m_halt || m_wait || (idle && e));
        check_val("stall",     32'(stall),     32'(exp_stall));
        check_val("wb_en",     32'(wb_en),     32'(m_done && m_read));
        check_val("wb_sel",    32'(wb_sel),    32'd10);
        check_val("wb_data",   wb_data,        m_wb_data);
        check_val("seg_value", seg_value,      m_seg);
        check_val("seg_valid", 32'(seg_valid), 32'(m_seg_valid));
        check_val("halted",    32'(halted),    32'(m_halt));
        obs_stall     = stall;
        obs_wb_en     = wb_en;
        obs_halted    = halted;
        obs_seg_valid = seg_valid;
        obs_wb_data   = wb_data;
        obs_seg       = seg_value;
        if (!r) mdl_step(e, a7, a0, sw, b);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int cnt;
        int dones;
        bit seen;
        logic [31:0] cap;
        logic cb;
        int halt_cycles;

        rst = 1'b1; ecall_i = 1'b0; a7_value = 32'd0; a0_value = 32'd0;
        switches = 16'h0000; confirm_btn = 1'b0;
        mdl_reset();
        #1;

        // Reset with ecall asserted: stall must stay low.
        repeat (3) cycle(1'b1, 32'd5, 32'd0, 16'h0000, 1'b0, 1'b1);
        check_val("reset_stall", 32'(obs_stall), 32'd0);
        repeat (2) cycle(1'b0, 32'd0, 32'd0, 16'h0000, 1'b0, 1'b0);

        // Unknown service: stall once, then one DONE with no writeback.
        cycle(1'b1, 32'd3, 32'd0, 16'h0000, 1'b0, 1'b0);
        check_val("noop_stall_first", 32'(obs_stall), 32'd1);
        cycle(1'b1, 32'd3, 32'd0, 16'h0000, 1'b0, 1'b0);
        check_val("noop_stall_done", 32'(obs_stall), 32'd0);
        check_val("noop_wb_en", 32'(obs_wb_en), 32'd0);
        cycle(1'b0, 32'd0, 32'd0, 16'h0000, 1'b0, 1'b0);

        // Print waits for a button rise; DONE three cycles after the rise.
        repeat (4) cycle(1'b1, 32'd1, 32'hDEADBEEF, 16'h0000, 1'b0, 1'b0);
        check_val("print_seg", obs_seg, 32'hDEADBEEF);
        check_val("print_seg_valid", 32'(obs_seg_valid), 32'd1);
        check_val("print_stall_held", 32'(obs_stall), 32'd1);
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 32'd1, 32'hDEADBEEF, 16'h0000, 1'b1, 1'b0);
            if (!obs_stall) begin
                lat = k;
                check_val("print_wb_en", 32'(obs_wb_en), 32'd0);
                break;
            end
        end
        check_val("print_latency", 32'(lat), 32'd3);

        // Read with button held across the ecall: needs a release and re-press.
        repeat (2) cycle(1'b0, 32'd0, 32'd0, 16'hA5C3, 1'b1, 1'b0);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 32'd5, 32'd0, 16'hA5C3, 1'b1, 1'b0);
            if (!obs_stall || obs_wb_en) cnt++;
        end
        check_val("read_held_no_done", 32'(cnt), 32'd0);
        repeat (3) cycle(1'b1, 32'd5, 32'd0, 16'hA5C3, 1'b0, 1'b0);
        cnt = 0; seen = 1'b0; cap = 32'd0;
        for (int k = 0; k < 10; k++) begin
            cycle(!seen, 32'd5, 32'd0, 16'hA5C3, 1'b1, 1'b0);
            if (obs_wb_en) begin
                cnt++;
                cap = obs_wb_data;
            end
            if (!obs_stall) seen = 1'b1;
        end
        check_val("read_wb_pulses", 32'(cnt), 32'd1);
        check_val("read_wb_data", cap, 32'h0000A5C3);
        cycle(1'b0, 32'd0, 32'd0, 16'h0000, 1'b0, 1'b0);

        // Reset in the middle of a read wait abandons it without a write.
        repeat (3) cycle(1'b1, 32'd5, 32'd0, 16'h1234, 1'b0, 1'b0);
        repeat (2) cycle(1'b1, 32'd5, 32'd0, 16'h1234, 1'b0, 1'b1);
        check_val("rst_mid_stall", 32'(obs_stall), 32'd0);
        check_val("rst_mid_seg_valid", 32'(obs_seg_valid), 32'd0);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 32'd0, 32'd0, 16'h1234, (k >= 2), 1'b0);
            if (obs_wb_en) cnt++;
        end
        check_val("rst_mid_no_write", 32'(cnt), 32'd0);
        cycle(1'b0, 32'd0, 32'd0, 16'h0000, 1'b0, 1'b0);

        // Back-to-back: print then no-op, each completes exactly once.
        dones = 0; seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            cycle(1'b1, 32'd1, 32'h00000042, 16'h0000, (k >= 2), 1'b0);
            if (!obs_stall) begin
                dones++;
                seen = 1'b1;
            end
        end
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            cycle(1'b1, 32'd3, 32'd0, 16'h0000, 1'b1, 1'b0);
            if (!obs_stall) begin
                dones++;
                seen = 1'b1;
            end
        end
        check_val("b2b_dones", 32'(dones), 32'd2);
        cycle(1'b0, 32'd0, 32'd0, 16'h0000, 1'b0, 1'b0);

        // Exit: absorbing for 1000 cycles despite button activity.
        cycle(1'b1, 32'd10, 32'd0, 16'h0000, 1'b0, 1'b0);
        cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            cycle(1'b1, 32'd10, 32'd0, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            if (!obs_stall || !obs_halted) cnt++;
        end
        check_val("exit_absorbing", 32'(cnt), 32'd0);
        cycle(1'b1, 32'd10, 32'd0, 16'h0000, 1'b0, 1'b1);
        check_val("exit_rst_halted", 32'(obs_halted), 32'd0);
        check_val("exit_rst_stall", 32'(obs_stall), 32'd0);
        cycle(1'b0, 32'd0, 32'd0, 16'h0000, 1'b0, 1'b0);

        // Randomized traffic against the model.
        cb = 1'b0;
        halt_cycles = 0;
        for (int i = 0; i < 4000; i++) begin
            logic        re;
            logic        rr;
            logic [31:0] ra7;
            if ($urandom_range(0, 5) == 0) cb = ~cb;
            re = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 9))
                0, 1, 2: ra7 = 32'd1;
                3, 4, 5: ra7 = 32'd5;
                6:       ra7 = 32'd10;
                default: ra7 = $urandom;
            endcase
            rr = ($urandom_range(0, 299) == 0) || (halt_cycles > 40);
            if (rr) halt_cycles = 0;
            else if (m_halt) halt_cycles++;
            cycle(re, ra7, $urandom, 16'($urandom), cb, rr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
